// File: rtl/frame_scanout_if.sv
// Scan-out bus: VGA timing requests, frame-buffer RAM port, pixel output.
// The slave side is the scan-out engine; master is timing + RAM.
interface frame_scanout_if #(
  parameter int H_ACTIVE = 64,
  parameter int V_ACTIVE = 48,
  parameter int PIX_W    = 9
);
  localparam int AW = $clog2(H_ACTIVE * V_ACTIVE);

  logic             frame_ready;
  logic             frame_start;
  logic             pixel_req;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic [PIX_W-1:0] pixel_out;
  logic             pixel_valid;
  logic             sync_err;
  logic             frame_done;

  modport master (
    output frame_ready, frame_start, pixel_req, rd_data,
    input  rd_en, rd_addr, pixel_out, pixel_valid,
    input  sync_err, frame_done
  );

  modport slave (
    input  frame_ready, frame_start, pixel_req, rd_data,
    output rd_en, rd_addr, pixel_out, pixel_valid,
    output sync_err, frame_done
  );
endinterface

// File: rtl/frame_scanout.sv
// Frame-buffer scan-out: raster walk with SCALExSCALE upscaling,
// fixed 2-cycle request-to-pixel latency, black until a frame is ready.
module frame_scanout #(
  parameter int H_ACTIVE = 64,
  parameter int V_ACTIVE = 48,
  parameter int SCALE    = 10,
  parameter int PIX_W    = 9
) (
  input  logic           clk,
  input  logic           reset,
  frame_scanout_if.slave bus
);
  localparam int AW = $clog2(H_ACTIVE * V_ACTIVE);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int SW = $clog2(SCALE);

  localparam logic [SW-1:0] S_MAX = SW'(SCALE - 1);
  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SCAN
  } state_t;

  state_t        r_state, w_state_n;
  logic [SW-1:0] r_sub_x, r_sub_y;
  logic [XW-1:0] r_src_x;
  logic [YW-1:0] r_src_y;
  logic [AW-1:0] r_row_base;
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic          r_sync_err;
  logic          r_frame_done;
  logic          r_v1, r_v2, r_live2;

  logic          w_restart, w_issue;
  logic          w_err_n, w_done_n;
  logic [SW-1:0] w_b_sx, w_b_sy, w_sx_n, w_sy_n;
  logic [XW-1:0] w_b_x, w_x_n;
  logic [YW-1:0] w_b_y, w_y_n;
  logic [AW-1:0] w_b_rb, w_rb_n, w_addr_n;
  logic [PIX_W-1:0] w_pix;

  always_comb begin
    w_state_n = r_state;
    w_restart = 1'b0;
    w_issue   = 1'b0;
    w_err_n   = 1'b0;
    w_done_n  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.frame_ready) w_state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.frame_start && bus.frame_ready) begin
          w_state_n = ST_SCAN;
          w_restart = 1'b1;
          w_issue   = bus.pixel_req;
        end else if (!bus.frame_ready) begin
          w_state_n = ST_IDLE;
        end
      end
      ST_SCAN: begin
        w_issue   = bus.pixel_req;
        w_restart = bus.frame_start;
        w_err_n   = bus.frame_start;
      end
      default: w_state_n = ST_IDLE;
    endcase

    // A restart zeroes the walk before a same-cycle request is served
    w_b_sx = w_restart ? '0 : r_sub_x;
    w_b_x  = w_restart ? '0 : r_src_x;
    w_b_sy = w_restart ? '0 : r_sub_y;
    w_b_y  = w_restart ? '0 : r_src_y;
    w_b_rb = w_restart ? '0 : r_row_base;

    w_sx_n   = w_b_sx;
    w_x_n    = w_b_x;
    w_sy_n   = w_b_sy;
    w_y_n    = w_b_y;
    w_rb_n   = w_b_rb;
    w_addr_n = r_rd_addr;

    if (w_issue) begin
      w_addr_n = w_b_rb + AW'(w_b_x);
      if (w_b_sx != S_MAX) begin
        w_sx_n = w_b_sx + SW'(1);
      end else begin
        w_sx_n = '0;
        if (w_b_x != X_MAX) begin
          w_x_n = w_b_x + XW'(1);
        end else begin
          w_x_n = '0;
          if (w_b_sy != S_MAX) begin
            w_sy_n = w_b_sy + SW'(1);
          end else begin
            w_sy_n = '0;
            if (w_b_y != Y_MAX) begin
              w_y_n  = w_b_y + YW'(1);
              w_rb_n = w_b_rb + AW'(H_ACTIVE);
            end else begin
              w_y_n     = '0;
              w_rb_n    = '0;
              w_done_n  = 1'b1;
              w_state_n = ST_WAIT;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_sub_x      <= '0;
      r_src_x      <= '0;
      r_sub_y      <= '0;
      r_src_y      <= '0;
      r_row_base   <= '0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_sync_err   <= 1'b0;
      r_frame_done <= 1'b0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_live2      <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_sub_x      <= w_sx_n;
      r_src_x      <= w_x_n;
      r_sub_y      <= w_sy_n;
      r_src_y      <= w_y_n;
      r_row_base   <= w_rb_n;
      r_rd_en      <= w_issue;
      r_rd_addr    <= w_addr_n;
      r_sync_err   <= w_err_n;
      r_frame_done <= w_done_n;
      r_v1         <= bus.pixel_req;
      r_v2         <= r_v1;
      r_live2      <= r_rd_en;
    end
  end

  // Black unless this slot's request actually read the RAM
  assign w_pix = (r_v2 && r_live2) ? bus.rd_data : '0;

  assign bus.rd_en       = r_rd_en;
  assign bus.rd_addr     = r_rd_addr;
  assign bus.pixel_out   = w_pix;
  assign bus.pixel_valid = r_v2;
  assign bus.sync_err    = r_sync_err;
  assign bus.frame_done  = r_frame_done;
endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout: vector table, scoreboard queue and a
// flat-index address model on a reduced 16x12 x4 geometry.
module tb_frame_scanout;
  localparam int H   = 16;
  localparam int V   = 12;
  localparam int S   = 4;
  localparam int PW  = 9;
  localparam int TOT = H * V * S * S;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_scanout_if #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW)
  ) bus ();

  frame_scanout #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SCALE(S), .PIX_W(PW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          rst, fr, fs, req;
    bit          x_rden, x_pv;
    logic [PW-1:0] x_pix;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int n_done = 0;

  logic [PW-1:0] sb[$];

  bit m_scan = 0, m_wait = 0;
  int m_idx = 0;
  bit e_rden = 0, e_err = 0, e_done = 0, e_req = 0;
  int e_addr = 0;
  bit q_rden, q_err, q_done, ev1, ev2;
  int q_addr;

  task automatic chk(input string nm, input int got,
                     input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] ram_f(input int a);
    return PW'(a) ^ 9'h155;
  endfunction

  function automatic int addr_of(input int idx);
    return (idx / (H*S*S)) * H + (idx % (H*S)) / S;
  endfunction

  always @(posedge clk)
    if (bus.rd_en) bus.rd_data <= ram_f(int'(bus.rd_addr));

  task automatic issue();
    e_rden = 1;
    e_addr = addr_of(m_idx);
    sb.push_back(ram_f(e_addr));
    m_idx++;
    if (m_idx == TOT) begin
      m_idx  = 0;
      m_scan = 0;
      m_wait = 1;
      e_done = 1;
    end
  endtask

  task automatic step(input bit rst, fr, fs, req);
    @(negedge clk);
    reset = rst;
    bus.frame_ready = fr;
    bus.frame_start = fs;
    bus.pixel_req   = req;
    e_rden = 0; e_err = 0; e_done = 0; e_req = req;
    if (rst) begin
      m_scan = 0; m_wait = 0; m_idx = 0;
      sb.delete();
      e_req = 0;
    end else if (m_scan) begin
      if (fs) begin
        m_idx = 0;
        e_err = 1;
      end
      if (req) issue();
    end else if (m_wait && fs && fr) begin
      m_scan = 1;
      m_idx  = 0;
      if (req) issue();
    end else begin
      if (req) sb.push_back('0);
      if (!m_wait && fr) m_wait = 1;
      else if (m_wait && !fr) m_wait = 0;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      q_rden <= 0; q_err <= 0; q_done <= 0;
      ev1 <= 0; ev2 <= 0;
    end else begin
      q_rden <= e_rden;
      q_addr <= e_addr;
      q_err  <= e_err;
      q_done <= e_done;
      ev1    <= e_req;
      ev2    <= ev1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (bus.frame_done) n_done++;
    chk("rd_en", int'(bus.rd_en), int'(q_rden));
    if (q_rden)
      chk("rd_addr", int'(bus.rd_addr), q_addr);
    chk("sync_err", int'(bus.sync_err), int'(q_err));
    chk("frame_done", int'(bus.frame_done), int'(q_done));
    chk("pixel_valid", int'(bus.pixel_valid), int'(ev2));
    if (bus.pixel_valid) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        logic [PW-1:0] x;
        x = sb.pop_front();
        chk("pixel_out", int'(bus.pixel_out), int'(x));
      end
    end
  end

  task automatic post();
    @(posedge clk);
    #3;
  endtask

  initial begin
    vec_t tv[11];
    int rem;
    bus.frame_ready = 0;
    bus.frame_start = 0;
    bus.pixel_req   = 0;
    for (int i = 0; i < 11; i++) begin
      tv[i].rst = (i < 3);
      tv[i].fr = 0; tv[i].fs = 0;
      tv[i].req = (i >= 3 && i <= 7);
      tv[i].x_rden = 0;
      tv[i].x_pv = (i >= 4 && i <= 8);
      tv[i].x_pix = '0;
    end

    for (int i = 0; i < 11; i++) begin
      step(tv[i].rst, tv[i].fr, tv[i].fs, tv[i].req);
      post();
      chk("tv_rd_en", int'(bus.rd_en), int'(tv[i].x_rden));
      chk("tv_valid", int'(bus.pixel_valid), int'(tv[i].x_pv));
      chk("tv_pix", int'(bus.pixel_out), int'(tv[i].x_pix));
      if (i == 2) begin
        chk("rst_addr", int'(bus.rd_addr), 0);
        chk("rst_done", int'(bus.frame_done), 0);
      end
    end

    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < TOT; ) begin
      if (i >= H*S && $urandom_range(0, 3) == 0) begin
        step(0, 1, 0, 0);
      end else begin
        step(0, 1, 0, 1);
        if (i == S - 1 || i == S) begin
          post();
          chk("subpix_addr", int'(bus.rd_addr), i / S);
        end
        if (i == H*S*S) begin
          post();
          chk("line_s_addr", int'(bus.rd_addr), H);
        end
        if (i == TOT - 1) begin
          post();
          chk("last_addr", int'(bus.rd_addr), H*V - 1);
          chk("done_pulse", int'(bus.frame_done), 1);
        end
        i++;
      end
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    post();
    chk("done_count", n_done, 1);

    step(0, 1, 1, 0);
    for (int i = 0; i < 100; i++) step(0, 1, 0, 1);
    step(0, 1, 1, 0);
    post();
    chk("sync_err_pulse", int'(bus.sync_err), 1);
    step(0, 1, 0, 1);
    post();
    chk("restart_addr", int'(bus.rd_addr), 0);
    for (int i = 0; i < 50; i++) step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    post();
    chk("same_cyc_err", int'(bus.sync_err), 1);
    chk("same_cyc_addr", int'(bus.rd_addr), 0);

    for (int i = 0; i < 1600; i++) step(0, 1, 0, 1);
    rem = TOT - m_idx;
    for (int i = 0; i < rem; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    post();
    chk("done_count2", n_done, 2);
    step(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    step(1, 1, 0, 0);
    post();
    chk("rst_mid_valid", int'(bus.pixel_valid), 0);
    chk("rst_mid_rd_en", int'(bus.rd_en), 0);
    chk("rst_mid_addr", int'(bus.rd_addr), 0);
    chk("rst_mid_pix", int'(bus.pixel_out), 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_scanout.md
# frame_scanout

Read side of the Mandelbrot frame buffer. It walks the H_ACTIVE×V_ACTIVE colour buffer in raster order and upscales each source pixel by SCALE in both axes. Each pixel is delivered on a per-pixel request from the VGA timing side. The block sits between the frame-buffer RAM (filled by the pipe/FIFO writer) and VGADriver, and shows black until the writer declares a complete frame.

## Interface
Parameters:
- H_ACTIVE, 64, source buffer width in pixels
- V_ACTIVE, 48, source buffer height in pixels
- SCALE, 10, replication factor per axis (64×48 → 640×480)
- PIX_W, 9, colour word width (3R:3G:3B)

Ports:
- clk  in  1  single clock (25 MHz pixel domain)
- reset  in  1  one clock; reset is synchronous and active-high
- frame_ready  in  1  level from writer; high = buffer holds a complete frame
- frame_start  in  1  one-cycle pulse from VGA timing at start of first active line
- pixel_req  in  1  high for each active-area pixel cycle
- rd_en  out  1  RAM read strobe
- rd_addr  out  $clog2(H_ACTIVE*V_ACTIVE)  RAM word address, row-major (y*H_ACTIVE + x)
- rd_data  in  PIX_W  RAM data, valid the cycle after rd_en (synchronous read)
- pixel_out  out  PIX_W  colour for VGADriver
- pixel_valid  out  1  pixel_out corresponds to a pixel_req issued 2 cycles earlier
- sync_err  out  1  one-cycle pulse: frame_start arrived mid-frame
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is requested

## Operation
- States: IDLE → WAIT_FRAME → SCAN → WAIT_FRAME.
  - IDLE: frame_ready low. Any pixel_req yields black (0). Go to WAIT_FRAME when frame_ready=1.
  - WAIT_FRAME: on frame_start with frame_ready=1, clear counters and enter SCAN. If frame_ready drops, return to IDLE.
  - SCAN: each pixel_req issues rd_en=1 with rd_addr = row_base + src_x, then advances the counters.
- Counters: sub_x, src_x, sub_y, src_y, row_base. row_base is a running sum (+H_ACTIVE per src_y step); no multiplier.
  - sub_x increments per pixel_req and wraps at SCALE-1. On wrap, src_x increments.
  - End of line is src_x=H_ACTIVE-1 with sub_x wrap: src_x←0, sub_x←0, sub_y++.
  - When sub_y wraps at SCALE-1, src_y++ and row_base += H_ACTIVE.
  - The last pixel of the frame is src_y=V_ACTIVE-1, sub_y=SCALE-1, src_x=H_ACTIVE-1, sub_x=SCALE-1. Its pixel_req pulses frame_done the next cycle and moves the FSM to WAIT_FRAME.
- Outside SCAN, pixel_req still produces pixel_valid with pixel_out=0 and no rd_en. Latency is the same 2 cycles.
- frame_start in SCAN, before the last pixel: pulse sync_err, restart the counters at (0,0), stay in SCAN.
- frame_start and pixel_req in the same cycle: frame_start applies first, and that request is pixel (0,0).
- frame_ready is sampled only at frame_start. Dropping it mid-SCAN does not abort the frame.
- pixel_req gaps (blanking) simply hold the counters. Lines are delimited by count, not by an hsync input.

## Timing
- Reset values: state IDLE, all counters 0, rd_en=0, rd_addr=0, pixel_out=0, pixel_valid=0, sync_err=0, frame_done=0.
- Reset mid-SCAN takes effect on the next edge. Any in-flight pixel_valid is dropped.
- Cycle N: pixel_req=1 → rd_en/rd_addr registered, visible in N+1. rd_data is valid in N+2 and drives pixel_out combinationally in that cycle.
- Timing rules:
  - pixel_valid is high in N+2.
  - Latency is fixed at 2, including the black path.
  - Back-to-back requests sustain 1 pixel/cycle.
- rd_addr is stable for SCALE consecutive requests within a source pixel. rd_en is asserted every request regardless.
- frame_done and sync_err are registered pulses in N+1 relative to the triggering input.

## Test plan
- Reset held 3 cycles, then 5 pixel_req with frame_ready=0 → rd_en never high; pixel_valid high on cycles 3–7 after the first req; pixel_out=0.
- RAM preloaded with data = addr[8:0]; frame_ready=1, frame_start, then 640 reqs → rd_addr 0 for reqs 0–9, 1 for 10–19 … 63 for 630–639; pixel_out follows 2 cycles later.
- Full 640×480 frame with random gaps in pixel_req → line 10 starts at addr 64 and line 479 ends at addr 3071; frame_done pulses once; the FSM then sits in WAIT_FRAME.
- frame_start after 1000 reqs in SCAN → sync_err pulse, next req reads addr 0; with a simultaneous pixel_req that same req reads addr 0.
- frame_ready dropped at req 5000 mid-frame → frame completes normally; at the next frame_start the output is black and the FSM goes to IDLE with no rd_en.
- reset asserted 1 cycle after a pixel_req → pixel_valid stays 0, all outputs return to reset values next cycle.
